// File: rtl/ac97_codec_responder.sv
// AC97 codec-side serial link responder: frames SDATA_IN, decodes register
// commands and playback samples from SDATA_OUT, and reports codec-ready.
module ac97_codec_responder #(
  parameter int          READY_FRAMES = 4,
  parameter logic [15:0] VENDOR_ID1   = 16'h4E53,
  parameter logic [15:0] VENDOR_ID2   = 16'h4350
) (
  input  logic        BIT_CLK,
  input  logic        reset_n,
  input  logic        SYNC,
  input  logic        SDATA_OUT,
  output logic        SDATA_IN,
  input  logic [15:0] adc_left,
  input  logic [15:0] adc_right,
  output logic [15:0] dac_left,
  output logic [15:0] dac_right,
  output logic        dac_strobe,
  output logic        codec_ready
);

  typedef struct packed {
    logic        rd;
    logic [6:0]  addr;
    logic [15:0] data;
  } cmd_t;

  localparam logic [15:0] READY_CNT   = 16'(READY_FRAMES);
  localparam logic [15:0] MASTER_DEF  = 16'h8000;
  localparam logic [15:0] PCM_DEF     = 16'h8808;
  localparam logic [15:0] REC_DEF     = 16'h0000;
  localparam logic [15:0] RATE_DEF    = 16'hBB80;

  logic        sync_q, sync_rise;
  logic [7:0]  cnt_q, pos;
  logic [94:0] rx_sr;
  logic [95:0] rx95;
  cmd_t        cmd;
  logic        cmd_vld, dac_vld;
  logic [15:0] master_vol, pcm_vol, rec_sel, dac_rate;
  logic        rd_pend;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data, tag_nxt;
  logic [15:0] frame_cnt;
  logic [95:0] frame_q, frame_nxt;
  logic        unused_msb;

  // pos is the frame bit index of the current cycle; a SYNC rise forces 0.
  always_comb begin
    sync_rise = SYNC & ~sync_q;
    pos       = sync_rise ? 8'd0 : ((cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1);
    rx95      = {rx_sr, SDATA_OUT};
    unused_msb = rx95[95];
    cmd       = '{rd: rx95[39], addr: rx95[38:32], data: rx95[19:4]};
    cmd_vld   = (pos == 8'd55) && (&rx95[55:53]);
    dac_vld   = (pos == 8'd95) && rx95[92] && rx95[91];
  end

  always_comb begin
    rd_data = 16'h0000;
    case (rd_addr)
      7'h02:   rd_data = master_vol;
      7'h18:   rd_data = pcm_vol;
      7'h1A:   rd_data = rec_sel;
      7'h2C:   rd_data = dac_rate;
      7'h26:   rd_data = {12'h000, {4{codec_ready}}};
      7'h7C:   rd_data = VENDOR_ID1;
      7'h7E:   rd_data = VENDOR_ID2;
      default: rd_data = 16'h0000;
    endcase
    tag_nxt   = {codec_ready, rd_pend, rd_pend, codec_ready, codec_ready, 11'h000};
    frame_nxt = {tag_nxt,
                 rd_pend ? {1'b0, rd_addr, 12'h000} : 20'h00000,
                 rd_pend ? {rd_data, 4'h0} : 20'h00000,
                 adc_left, 4'h0,
                 adc_right, 4'h0};
  end

  always_ff @(posedge BIT_CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 1'b1;
      cnt_q       <= 8'hFF;
      rx_sr       <= '0;
      frame_q     <= '0;
      SDATA_IN    <= 1'b0;
      master_vol  <= MASTER_DEF;
      pcm_vol     <= PCM_DEF;
      rec_sel     <= REC_DEF;
      dac_rate    <= RATE_DEF;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      frame_cnt   <= '0;
      codec_ready <= 1'b0;
      dac_left    <= '0;
      dac_right   <= '0;
      dac_strobe  <= 1'b0;
    end else begin
      sync_q     <= SYNC;
      cnt_q      <= pos;
      rx_sr      <= rx95[94:0];
      dac_strobe <= dac_vld;

      // Whole outgoing frame is snapshotted at the SYNC rise; bit 0 goes out directly.
      if (sync_rise) begin
        frame_q  <= {frame_nxt[94:0], 1'b0};
        SDATA_IN <= frame_nxt[95];
        rd_pend  <= 1'b0;
      end else begin
        frame_q  <= {frame_q[94:0], 1'b0};
        SDATA_IN <= (pos == 8'hFF) ? 1'b0 : frame_q[95];
      end

      if (cmd_vld) begin
        if (cmd.rd) begin
          rd_pend <= 1'b1;
          rd_addr <= cmd.addr;
        end else begin
          case (cmd.addr)
            7'h00: begin
              master_vol <= MASTER_DEF;
              pcm_vol    <= PCM_DEF;
              rec_sel    <= REC_DEF;
              dac_rate   <= RATE_DEF;
            end
            7'h02:   master_vol <= cmd.data;
            7'h18:   pcm_vol    <= cmd.data;
            7'h1A:   rec_sel    <= cmd.data;
            7'h2C:   dac_rate   <= cmd.data;
            default: ;
          endcase
        end
      end

      if (dac_vld) begin
        dac_left  <= rx95[39:24];
        dac_right <= rx95[19:4];
      end

      // A frame counts as complete only when it walks from 254 into 255.
      if (pos == 8'hFF && cnt_q == 8'hFE && !codec_ready) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (frame_cnt + 16'd1 >= READY_CNT) codec_ready <= 1'b1;
      end
    end
  end

endmodule
